// File: rtl/mdu_unit_if.sv
// Multiply/divide unit bus: operation request from the pipeline, and busy/HI/LO
// returned by the unit. The master is the EX stage; the slave is mdu_unit.
//
// Request semantics: the request is a single-cycle pulse that is sampled on
// the rising edge.
// - A start pulse with a mult/multu/div/divu op is accepted only while busy=0.
// - A start pulse arriving while busy=1 is dropped, not queued.
// - mthi/mtlo use start=0 and take effect on the same edge when busy=0.
interface mdu_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       MDUOp;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, MDUOp, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, MDUOp, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with its own HI/LO registers.
// - Operands are latched at launch.
// - The result is formed combinationally from the latched operands and
//   committed on the edge where the cycle counter goes 1 -> 0.
// - busy, HI and LO are all plain register outputs.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_unit_if.slave  bus,
    output logic       dbg_state_o
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0]       MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0]       DIV_N  = 4'(DIV_CYCLES);
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;

    logic             launch_ok;
    logic             finish;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] prod_u;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, b_safe, b_mag_safe;
    logic [WIDTH-1:0] uq, ur, sq, sr;
    logic [WIDTH-1:0] quo_u, rem_u, quo_s, rem_s;

    assign launch_ok = bus.start && (bus.MDUOp >= OP_MULT) && (bus.MDUOp <= OP_DIVU);
    assign finish    = (state_q == S_RUN) && (cnt_q == 4'd1);

    // State, operand latches and HI/LO registers; reset drops any in-flight op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: launch from IDLE, count down in RUN, return to IDLE on the last cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (launch_ok) begin
                    state_d = S_RUN;
                    cnt_d   = (bus.MDUOp <= OP_MULTU) ? MULT_N : DIV_N;
                    op_d    = bus.MDUOp;
                    a_d     = bus.A;
                    b_d     = bus.B;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Arithmetic on the latched operands; signed divide goes through magnitudes
    // so the most-negative / -1 case wraps to the dividend with a zero remainder
    always_comb begin
        prod_s     = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
        prod_u     = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        a_neg      = a_q[WIDTH-1];
        b_neg      = b_q[WIDTH-1];
        a_mag      = a_neg ? (~a_q + ONE) : a_q;
        b_mag      = b_neg ? (~b_q + ONE) : b_q;
        b_safe     = (b_q == '0) ? ONE : b_q;
        b_mag_safe = (b_q == '0) ? ONE : b_mag;
        quo_u      = a_q / b_safe;
        rem_u      = a_q % b_safe;
        uq         = a_mag / b_mag_safe;
        ur         = a_mag % b_mag_safe;
        sq         = (a_neg ^ b_neg) ? (~uq + ONE) : uq;
        sr         = a_neg ? (~ur + ONE) : ur;
        quo_s      = sq;
        rem_s      = sr;
    end

    // HI/LO update: op result on the finishing edge, mthi/mtlo only when idle
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (finish) begin
            case (op_q)
                OP_MULT: begin
                    hi_d = prod_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_s[WIDTH-1:0];
                end
                OP_MULTU: begin
                    hi_d = prod_u[2*WIDTH-1:WIDTH];
                    lo_d = prod_u[WIDTH-1:0];
                end
                OP_DIV: begin
                    if (b_q != '0) begin
                        hi_d = rem_s;
                        lo_d = quo_s;
                    end
                end
                OP_DIVU: begin
                    if (b_q != '0) begin
                        hi_d = rem_u;
                        lo_d = quo_u;
                    end
                end
                default: begin
                    hi_d = hi_q;
                end
            endcase
        end else if ((state_q == S_IDLE) && !bus.start) begin
            if (bus.MDUOp == OP_MTHI) hi_d = bus.A;
            if (bus.MDUOp == OP_MTLO) lo_d = bus.A;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.HI      = hi_q;
    assign bus.LO      = lo_q;
    assign dbg_state_o = state_q;
endmodule
